// File: rtl/shift_reg8_ctrl_pkg.sv
// Shared definitions for the shift register stage: FSM state codes,
// per-bit select codes and shift direction constants.
package shift_reg8_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LOAD  = 2'b01,
    SEL_SHIFT = 2'b10
  } sel_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_reg8_ctrl_reg_bit_cell.sv
// One register bit: select among hold, parallel data and shift neighbour,
// followed by a flop with synchronous active-high reset.
module reg_bit_cell
  import shift_reg8_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  sel_t sel,
  input  logic d,
  input  logic shift_in,
  output logic q
);

  logic q_next;

  always_comb begin
    q_next = q;
    case (sel)
      SEL_LOAD:  q_next = d;
      SEL_SHIFT: q_next = shift_in;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q_next;
  end

endmodule

// File: rtl/shift_reg8_ctrl.sv
// WIDTH-bit register with parallel load and a START-triggered run of exactly
// WIDTH serial shifts, reported to the sequencer through BUSY/DONE.
module shift_reg8_ctrl
  import shift_reg8_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             START,
  input  logic             DIR,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE,
  output state_t           state
);

  logic             dir_r;
  logic [CNT_W-1:0] count;
  sel_t             sel;
  logic [WIDTH-1:0] nbr;

  // Counter, latched direction and state share one clocked block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      dir_r <= DIR_RIGHT;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START && !LOAD) begin
            dir_r <= DIR;
            count <= CNT_W'(WIDTH - 1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (count == '0) state <= ST_FIN;
          else             count <= count - 1'b1;
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state == ST_SHIFT);
  assign DONE = (state == ST_FIN);
  assign SOUT = (dir_r == DIR_LEFT) ? Q[WIDTH-1] : Q[0];

  // LOAD only acts in IDLE; every other state (including the illegal code) holds Q.
  always_comb begin
    sel = SEL_HOLD;
    case (state)
      ST_IDLE:  sel = LOAD ? SEL_LOAD : SEL_HOLD;
      ST_SHIFT: sel = SEL_SHIFT;
      default:  sel = SEL_HOLD;
    endcase
  end

  assign nbr = (dir_r == DIR_LEFT) ? {Q[WIDTH-2:0], SIN} : {SIN, Q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit_cell u_cell (
      .clk      (CLK),
      .rst      (RST),
      .sel      (sel),
      .d        (D[i]),
      .shift_in (nbr[i]),
      .q        (Q[i])
    );
  end

endmodule

// File: tb/tb_shift_reg8_ctrl.sv
// Randomised scoreboard bench for shift_reg8_ctrl: stimulus pushes expected
// SOUT bits and final Q values; a negedge monitor pops and compares them.
module tb_shift_reg8_ctrl;
  import shift_reg8_ctrl_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, LOAD, START, DIR, SIN;
  logic [W-1:0] D, Q;
  logic         SOUT, BUSY, DONE;
  state_t       state;

  shift_reg8_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .START(START), .DIR(DIR),
    .SIN(SIN), .Q(Q), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE), .state(state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int           vectors = 0;
  int           miscompares = 0;
  int           busy_run = 0;
  logic [W-1:0] model;
  logic         exp_sout_q[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: shifting out WIDTH bits emits the old contents MSB-first (left)
  // or LSB-first (right); the result is the SIN sequence, reversed for left.
  task automatic push_run(input logic dir, input logic [W-1:0] s);
    logic [W-1:0] fin;
    for (int k = 0; k < W; k++) begin
      exp_sout_q.push_back(dir ? model[W-1-k] : model[k]);
      fin[W-1-k] = s[k];
    end
    exp_q.push_back(dir ? fin : s);
    model = dir ? fin : s;
  endtask

  // driver tasks
  task automatic do_load(input logic [W-1:0] v);
    LOAD = 1'b1;
    D    = v;
    step();
    LOAD = 1'b0;
    model = v;
    @(negedge CLK);
    chk("load_q", Q, v);
  endtask

  task automatic run(input logic dir, input logic [W-1:0] s, input bit disturb);
    START = 1'b1;
    DIR   = dir;
    push_run(dir, s);
    step();
    START = 1'b0;
    for (int k = 0; k < W; k++) begin
      SIN = s[k];
      if (disturb) begin
        LOAD  = 1'($urandom_range(0, 1));
        D     = W'($urandom);
        START = 1'($urandom_range(0, 1));
        DIR   = 1'($urandom_range(0, 1));
      end
      step();
    end
    LOAD  = 1'b0;
    START = 1'b0;
    DIR   = 1'b0;
    step();
    chk("done_seen", exp_q.size(), 0);
    chk("sout_drained", exp_sout_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RST) begin
      busy_run = 0;
    end else begin
      if (BUSY) begin
        busy_run++;
        if (exp_sout_q.size() == 0) chk("busy_unexpected", exp_sout_q.size(), 1);
        else                        chk("sout", SOUT, exp_sout_q.pop_front());
      end
      if (DONE) begin
        chk("busy_len", busy_run, W);
        chk("busy_in_done", BUSY, 0);
        if (exp_q.size() == 0) chk("done_unexpected", exp_q.size(), 1);
        else                   chk("done_q", Q, exp_q.pop_front());
        busy_run = 0;
      end
    end
  end

  initial begin
    logic [W-1:0] s;
    RST = 1'b1; LOAD = 1'b1; D = 8'hFF; START = 1'b0; DIR = 1'b0; SIN = 1'b0;
    step();
    step();
    @(negedge CLK);
    chk("rst_q", Q, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sout", SOUT, 0);
    chk("rst_state", state, ST_IDLE);
    RST = 1'b0; LOAD = 1'b0;
    model = '0;
    step();

    do_load(8'h5A);
    step();
    @(negedge CLK);
    chk("hold_q", Q, 8'h5A);

    do_load(8'h00);
    run(1'b1, 8'hCD, 1'b0);
    chk("left_result", Q, 8'hB3);

    do_load(8'hA5);
    run(1'b0, 8'h00, 1'b0);
    chk("right_result", Q, 8'h00);

    do_load(8'h3C);
    run(1'b1, W'($urandom), 1'b1);
    do_load(8'hC3);
    run(1'b0, W'($urandom), 1'b1);

    LOAD = 1'b1; START = 1'b1; D = 8'h99;
    step();
    LOAD = 1'b0; START = 1'b0;
    model = 8'h99;
    @(negedge CLK);
    chk("load_start_q", Q, 8'h99);
    chk("load_start_busy", BUSY, 0);
    step();
    chk("load_start_state", state, ST_IDLE);

    // reset landing on the fourth shift edge
    START = 1'b1; DIR = 1'b1;
    push_run(1'b1, W'($urandom));
    step();
    START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      SIN = 1'($urandom_range(0, 1));
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_sout_q.delete();
    exp_q.delete();
    model = '0;
    @(negedge CLK);
    chk("midrst_q", Q, 8'h00);
    chk("midrst_state", state, ST_IDLE);
    chk("midrst_busy", BUSY, 0);
    repeat (12) step();
    run(1'b0, W'($urandom), 1'b0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: do_load(W'($urandom));
        1: run(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        default: begin
          repeat ($urandom_range(1, 3)) step();
          @(negedge CLK);
          chk("idle_hold_q", Q, model);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
